logit_pwl_pipe: RTL

Pipelined piecewise-linear inverse sigmoid (logit) matching the team's 5-segment PWL sigmoid, so that logit(sigmoid(x)) ≈ x for diagnostics and GRU gate back-mapping. The block accepts signed fixed-point gate values y and returns x, using shift-add arithmetic only. It uses a valid/ready stream on both sides and has a 2-stage pipeline with backpressure. It sits between gate-activation outputs and the debug/analysis datapath.

---
 rtl/logit_pwl_pipe_pkg.sv | 46 ++++
 rtl/logit_pwl_pipe_seg_classify.sv | 38 +++
 rtl/logit_pwl_pipe.sv | 131 +++++++++++++
 3 files changed

// File: rtl/logit_pwl_pipe_pkg.sv
// Shared fixed-point constants and segment encoding for the PWL sigmoid/logit pair.
package gru_fixed_pkg;

    // Q format used by the segment constants (1.0 == 256)
    localparam int Q_FRAC  = 8;
    localparam int ONE     = 256;

    // Logit output clamp, +/-5.0
    localparam int X_CLAMP = 1280;

    // Sigmoid-domain breakpoints (raw codes)
    localparam int Y_BP_0   = 0;
    localparam int Y_BP_20  = 20;
    localparam int Y_BP_64  = 64;
    localparam int Y_BP_192 = 192;
    localparam int Y_BP_236 = 236;
    localparam int Y_BP_256 = 256;

    // Per-segment slope (as a left shift) and offset: X = (Y << SHIFT) + OFFSET
    localparam int SEG1_SHIFT  = 5;
    localparam int SEG1_OFFSET = -1280;
    localparam int SEG2_SHIFT  = 3;
    localparam int SEG2_OFFSET = -768;
    localparam int SEG3_SHIFT  = 2;
    localparam int SEG3_OFFSET = -512;
    localparam int SEG4_SHIFT  = 3;
    localparam int SEG4_OFFSET = -1280;
    localparam int SEG5_SHIFT  = 5;
    localparam int SEG5_OFFSET = -6912;

    typedef enum logic [2:0] {
        SEG_LO_SAT = 3'd0,
        SEG_1      = 3'd1,
        SEG_2      = 3'd2,
        SEG_3      = 3'd3,
        SEG_4      = 3'd4,
        SEG_5      = 3'd5,
        SEG_HI_SAT = 3'd6
    } pwl_seg_e;

    // True for the two clamped end segments
    function automatic logic seg_is_sat(input pwl_seg_e seg);
        return (seg == SEG_LO_SAT) || (seg == SEG_HI_SAT);
    endfunction

endpackage

// File: rtl/logit_pwl_pipe_seg_classify.sv
// Combinational segment classifier: maps a signed sigmoid-domain code to its PWL segment.
module logit_seg_classify
    import gru_fixed_pkg::*;
#(
    parameter int WIDTH = 17
) (
    input  logic signed [WIDTH-1:0] in_y,
    output pwl_seg_e                seg
);

    localparam logic signed [WIDTH-1:0] BP_0   = WIDTH'(Y_BP_0);
    localparam logic signed [WIDTH-1:0] BP_20  = WIDTH'(Y_BP_20);
    localparam logic signed [WIDTH-1:0] BP_64  = WIDTH'(Y_BP_64);
    localparam logic signed [WIDTH-1:0] BP_192 = WIDTH'(Y_BP_192);
    localparam logic signed [WIDTH-1:0] BP_236 = WIDTH'(Y_BP_236);
    localparam logic signed [WIDTH-1:0] BP_256 = WIDTH'(Y_BP_256);

    // Signed breakpoint ladder; upper bounds inclusive except the last linear segment
    always_comb begin
        seg = SEG_LO_SAT;
        if (in_y <= BP_0) begin
            seg = SEG_LO_SAT;
        end else if (in_y <= BP_20) begin
            seg = SEG_1;
        end else if (in_y <= BP_64) begin
            seg = SEG_2;
        end else if (in_y <= BP_192) begin
            seg = SEG_3;
        end else if (in_y <= BP_236) begin
            seg = SEG_4;
        end else if (in_y < BP_256) begin
            seg = SEG_5;
        end else begin
            seg = SEG_HI_SAT;
        end
    end

endmodule

// File: rtl/logit_pwl_pipe.sv
// Two-stage pipelined piecewise-linear logit (inverse of the 5-segment PWL sigmoid).
// Stage 1 registers the input and its segment; stage 2 applies shift-add and clamp.
module logit_pwl_pipe
    import gru_fixed_pkg::*;
#(
    parameter int INT_WIDTH  = 8,
    parameter int FRAC_WIDTH = 8,
    parameter int WIDTH      = INT_WIDTH + FRAC_WIDTH + 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_x,
    output logic                    out_sat,
    output logic [2:0]              out_seg
);

    // Headroom for a shift by up to 5 plus the offset add
    localparam int EXT_W = WIDTH + 6;

    localparam logic signed [EXT_W-1:0] X_HI = EXT_W'(X_CLAMP);
    localparam logic signed [EXT_W-1:0] X_LO = EXT_W'(-X_CLAMP);

    logic                    en;
    pwl_seg_e                cls_seg;

    logic                    s1_valid;
    logic signed [WIDTH-1:0] s1_y;
    pwl_seg_e                s1_seg;

    logic signed [EXT_W-1:0] y_ext;
    logic signed [EXT_W-1:0] prod;
    logic signed [EXT_W-1:0] offset;
    logic signed [EXT_W-1:0] sum;
    logic signed [EXT_W-1:0] clamped;
    logic [2:0]              shamt;
    logic signed [WIDTH-1:0] x_next;
    logic                    sat_next;

    // The whole pipe advances together; a full, unaccepted output stalls everything
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    logit_seg_classify #(
        .WIDTH (WIDTH)
    ) u_classify (
        .in_y (in_y),
        .seg  (cls_seg)
    );

    // Stage 1 register: capture input, its valid bit and its segment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_y     <= '0;
            s1_seg   <= SEG_LO_SAT;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_y     <= in_y;
            s1_seg   <= cls_seg;
        end
    end

    // Stage 2 datapath: per-segment shift and offset, then clamp to +/-5.0
    always_comb begin
        y_ext    = EXT_W'(s1_y);
        shamt    = 3'd0;
        offset   = '0;
        sat_next = seg_is_sat(s1_seg);
        case (s1_seg)
            SEG_1: begin
                shamt  = 3'(SEG1_SHIFT);
                offset = EXT_W'(SEG1_OFFSET);
            end
            SEG_2: begin
                shamt  = 3'(SEG2_SHIFT);
                offset = EXT_W'(SEG2_OFFSET);
            end
            SEG_3: begin
                shamt  = 3'(SEG3_SHIFT);
                offset = EXT_W'(SEG3_OFFSET);
            end
            SEG_4: begin
                shamt  = 3'(SEG4_SHIFT);
                offset = EXT_W'(SEG4_OFFSET);
            end
            SEG_5: begin
                shamt  = 3'(SEG5_SHIFT);
                offset = EXT_W'(SEG5_OFFSET);
            end
            default: begin
                shamt  = 3'd0;
                offset = '0;
            end
        endcase
        prod = y_ext <<< shamt;
        sum  = prod + offset;
        if (s1_seg == SEG_LO_SAT) begin
            clamped = X_LO;
        end else if (s1_seg == SEG_HI_SAT) begin
            clamped = X_HI;
        end else if (sum > X_HI) begin
            clamped = X_HI;
        end else if (sum < X_LO) begin
            clamped = X_LO;
        end else begin
            clamped = sum;
        end
        x_next = WIDTH'(clamped);
    end

    // Stage 2 register: drives all outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_sat   <= 1'b0;
            out_seg   <= 3'd0;
        end else if (en) begin
            out_valid <= s1_valid;
            out_x     <= x_next;
            out_sat   <= sat_next;
            out_seg   <= s1_seg;
        end
    end

endmodule
